// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline.
// It keeps a small shadow of the EX, MEM and WB instructions' register tags.
// From that shadow and the instruction in ID it produces:
//   - the stall, flush, bubble and hold controls;
//   - the EX-stage operand forwarding selects;
//   - saturating stall and flush event counters.
//
// Mode table (selected combinationally every cycle, highest priority first)
//   state    | meaning
//   MEM_WAIT | data memory busy: freeze the whole pipe, ignore redirects
//   REDIRECT | taken branch/jump in EX: flush IF/ID, bubble into ID/EX
//   LU_STALL | ID reads the register a load in EX is producing: hold one cycle
//   RUN      | normal flow, no control asserted
module hazard_ctrl #(
   parameter int CNT_W     = 16,
   parameter int XLEN_REGS = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid,
   input  logic [6:0]                   id_opcode,
   input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
   input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
   input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
   input  logic                         ex_redirect,
   input  logic                         mem_busy,
   output logic                         pc_stall,
   output logic                         ifid_stall,
   output logic                         ifid_flush,
   output logic                         idex_bubble,
   output logic                         pipe_hold,
   output logic [1:0]                   fwd_a,
   output logic [1:0]                   fwd_b,
   output logic [CNT_W-1:0]             stall_cnt,
   output logic [CNT_W-1:0]             flush_cnt
);

   localparam int TAG_W = $clog2(XLEN_REGS);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      REDIRECT = 2'd2,
      MEM_WAIT = 2'd3
   } mode_t;

   mode_t mode;

   // decoded ID fields
   logic             writes_rd;
   logic             is_load;
   logic             uses_rs1;
   logic             uses_rs2;
   logic [TAG_W-1:0] id_src1;
   logic [TAG_W-1:0] id_src2;

   // shadow of the instructions downstream of ID
   logic             ex_v;
   logic [TAG_W-1:0] ex_rd;
   logic             ex_wr;
   logic             ex_ld;
   logic [TAG_W-1:0] ex_rs1;
   logic [TAG_W-1:0] ex_rs2;
   logic             mem_v;
   logic [TAG_W-1:0] mem_rd;
   logic             mem_wr;
   logic             wb_v;
   logic [TAG_W-1:0] wb_rd;
   logic             wb_wr;

   // controls stay quiet after reset until the first real instruction shows up
   logic             armed;
   logic             active;
   logic             load_use;

   // classify the ID instruction by opcode; unused source fields are masked to x0
   always_comb begin
      writes_rd = 1'b0;
      is_load   = 1'b0;
      uses_rs1  = 1'b1;
      uses_rs2  = 1'b0;
      if (id_opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
         writes_rd = (id_rd != '0);
      if (id_opcode == OP_LOAD)
         is_load = 1'b1;
      if (id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL})
         uses_rs1 = 1'b0;
      if (id_opcode inside {OP_REG, OP_STORE, OP_BRANCH})
         uses_rs2 = 1'b1;
      id_src1 = uses_rs1 ? id_rs1 : '0;
      id_src2 = uses_rs2 ? id_rs2 : '0;
   end

   // load in EX whose result the ID instruction needs right away
   always_comb begin
      load_use = 1'b0;
      if (id_valid && ex_v && ex_ld && ex_wr) begin
         if (id_src1 != '0 && id_src1 == ex_rd)
            load_use = 1'b1;
         if (id_src2 != '0 && id_src2 == ex_rd)
            load_use = 1'b1;
      end
   end

   // pick the pipeline mode; memory stall outranks redirect, which outranks load-use
   always_comb begin
      active = !rst && (armed || id_valid);
      mode   = RUN;
      if (active) begin
         if (mem_busy)
            mode = MEM_WAIT;
         else if (ex_redirect)
            mode = REDIRECT;
         else if (load_use)
            mode = LU_STALL;
      end
   end

   // control outputs are a pure function of the mode (zero-latency)
   always_comb begin
      pc_stall    = (mode == MEM_WAIT) || (mode == LU_STALL);
      ifid_stall  = (mode == MEM_WAIT) || (mode == LU_STALL);
      ifid_flush  = (mode == REDIRECT);
      idex_bubble = (mode == REDIRECT) || (mode == LU_STALL);
      pipe_hold   = (mode == MEM_WAIT);
   end

   // EX operand sources: the youngest older writer (MEM) wins over WB
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (ex_v) begin
         if (ex_rs1 != '0) begin
            if (mem_v && mem_wr && mem_rd == ex_rs1)
               fwd_a = FWD_MEM;
            else if (wb_v && wb_wr && wb_rd == ex_rs1)
               fwd_a = FWD_WB;
         end
         if (ex_rs2 != '0) begin
            if (mem_v && mem_wr && mem_rd == ex_rs2)
               fwd_b = FWD_MEM;
            else if (wb_v && wb_wr && wb_rd == ex_rs2)
               fwd_b = FWD_WB;
         end
      end
   end

   // advance the tag shadow; a memory wait freezes it, a bubble empties EX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_v   <= 1'b0;
         ex_rd  <= '0;
         ex_wr  <= 1'b0;
         ex_ld  <= 1'b0;
         ex_rs1 <= '0;
         ex_rs2 <= '0;
         mem_v  <= 1'b0;
         mem_rd <= '0;
         mem_wr <= 1'b0;
         wb_v   <= 1'b0;
         wb_rd  <= '0;
         wb_wr  <= 1'b0;
      end else if (mode != MEM_WAIT) begin
         mem_v  <= ex_v;
         mem_rd <= ex_rd;
         mem_wr <= ex_wr;
         wb_v   <= mem_v;
         wb_rd  <= mem_rd;
         wb_wr  <= mem_wr;
         if (mode == RUN) begin
            ex_v   <= id_valid;
            ex_rd  <= id_rd;
            ex_wr  <= writes_rd;
            ex_ld  <= is_load;
            ex_rs1 <= id_src1;
            ex_rs2 <= id_src2;
         end else begin
            ex_v   <= 1'b0;
            ex_rd  <= '0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
         end
      end
   end

   // remember that a real instruction has been seen since reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         armed <= 1'b0;
      else if (id_valid)
         armed <= 1'b1;
   end

   // saturating event counters; they stop at all-ones rather than wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (ifid_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences.
// A reference model tracks the in-flight instructions as a small array,
// and the bench compares against it every cycle.
// Literal checks pin the expected results of the key scenarios.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             id_valid = 1'b0;
   logic [6:0]       id_opcode = '0;
   logic [4:0]       id_rd = '0;
   logic [4:0]       id_rs1 = '0;
   logic [4:0]       id_rs2 = '0;
   logic             ex_redirect = 1'b0;
   logic             mem_busy = 1'b0;
   logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_hold;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   hazard_ctrl #(.CNT_W(CNT_W), .XLEN_REGS(32)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ins_t;

   ins_t       m_pipe [0:2];   // 0 = EX, 1 = MEM, 2 = WB
   int         m_stall;
   int         m_flush;
   logic       m_armed;
   logic [4:0] m_ctl;          // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_hold}

   function automatic ins_t decode_id();
      ins_t   d;
      logic   u1, u2;
      d.v  = id_valid;
      d.rd = id_rd;
      d.wr = (id_opcode inside {OP_R, OP_I, OP_LD, OP_LUI, OP_AUI, OP_JAL, OP_JALR}) && id_rd != 0;
      d.ld = (id_opcode == OP_LD);
      u1   = !(id_opcode inside {OP_LUI, OP_AUI, OP_JAL});
      u2   = id_opcode inside {OP_R, OP_ST, OP_BR};
      d.rs1 = u1 ? id_rs1 : 5'd0;
      d.rs2 = u2 ? id_rs2 : 5'd0;
      return d;
   endfunction

   function automatic logic [4:0] model_ctl();
      ins_t d;
      ins_t e;
      logic lu;
      d = decode_id();
      e = m_pipe[0];
      if (rst || !(m_armed || id_valid)) return 5'b00000;
      if (mem_busy)    return 5'b11001;
      if (ex_redirect) return 5'b00110;
      lu = id_valid && e.v && e.ld && e.wr &&
           ((d.rs1 != 0 && d.rs1 == e.rd) || (d.rs2 != 0 && d.rs2 == e.rd));
      return lu ? 5'b11010 : 5'b00000;
   endfunction

   // nearest older writer of src: 1 = MEM slot, 2 = WB slot, 0 = register file
   function automatic int fwd_for(logic [4:0] src);
      if (!m_pipe[0].v || src == 0) return 0;
      for (int s = 1; s <= 2; s++)
         if (m_pipe[s].v && m_pipe[s].wr && m_pipe[s].rd == src) return s;
      return 0;
   endfunction

   always_comb m_ctl = model_ctl();

   // model state advances with the clock and clears on reset
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) m_pipe[i] <= '0;
         m_stall <= 0;
         m_flush <= 0;
         m_armed <= 1'b0;
      end else begin
         if (!m_ctl[0]) begin
            m_pipe[2] <= m_pipe[1];
            m_pipe[1] <= m_pipe[0];
            m_pipe[0] <= m_ctl[1] ? '0 : decode_id();
         end
         if (id_valid) m_armed <= 1'b1;
         if (m_ctl[4] && m_stall < CMAX) m_stall <= m_stall + 1;
         if (m_ctl[2] && m_flush < CMAX) m_flush <= m_flush + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("pc_stall",    pc_stall,    m_ctl[4]);
      chk("ifid_stall",  ifid_stall,  m_ctl[3]);
      chk("ifid_flush",  ifid_flush,  m_ctl[2]);
      chk("idex_bubble", idex_bubble, m_ctl[1]);
      chk("pipe_hold",   pipe_hold,   m_ctl[0]);
      chk("fwd_a",       fwd_a,       fwd_for(m_pipe[0].rs1));
      chk("fwd_b",       fwd_b,       fwd_for(m_pipe[0].rs2));
      chk("stall_cnt",   stall_cnt,   m_stall);
      chk("flush_cnt",   flush_cnt,   m_flush);
   end

   // drive one cycle of ID/control inputs, return just after the following negedge
   task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic red, input logic busy);
      @(posedge clk);
      #1;
      id_valid    = v;
      id_opcode   = op;
      id_rd       = rd;
      id_rs1      = rs1;
      id_rs2      = rs2;
      ex_redirect = red;
      mem_busy    = busy;
      @(negedge clk);
      #1;
   endtask

   task automatic nop();
      step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_pc_stall", pc_stall, 0);
      chk("rst_cnt", stall_cnt, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ctl", {pc_stall, ifid_flush, idex_bubble, pipe_hold}, 0);

      // R-type chain: add x5; add x6,x5,x7; add x8,x5,x0
      step(1, OP_R, 5, 1, 2, 0, 0);
      step(1, OP_R, 6, 5, 7, 0, 0);
      step(1, OP_R, 8, 5, 0, 0, 0);
      chk("chain_fwd_a_mem", fwd_a, 1);
      chk("chain_fwd_b", fwd_b, 0);
      nop();
      chk("chain_fwd_a_wb", fwd_a, 2);

      // load-use: lw x3,0(x1); add x4,x3,x2
      step(1, OP_LD, 3, 1, 0, 0, 0);
      step(1, OP_R, 4, 3, 2, 0, 0);
      chk("lu_pc_stall", pc_stall, 1);
      chk("lu_ifid_stall", ifid_stall, 1);
      chk("lu_bubble", idex_bubble, 1);
      step(1, OP_R, 4, 3, 2, 0, 0);
      chk("lu_released", pc_stall, 0);
      nop();
      chk("lu_fwd_a_wb", fwd_a, 2);
      chk("lu_stall_cnt", stall_cnt, 1);

      // redirect outranks a load-use in ID
      step(1, OP_LD, 9, 1, 0, 0, 0);
      step(1, OP_R, 10, 9, 0, 1, 0);
      chk("red_flush", ifid_flush, 1);
      chk("red_bubble", idex_bubble, 1);
      chk("red_pc_stall", pc_stall, 0);
      nop();
      chk("red_flush_cnt", flush_cnt, 1);
      chk("red_fwd_a", fwd_a, 0);
      chk("red_fwd_b", fwd_b, 0);

      // memory wait with a pending redirect
      for (int i = 0; i < 3; i++) begin
         step(1, OP_R, 11, 1, 2, 1, 1);
         chk("mw_hold", pipe_hold, 1);
         chk("mw_pc_stall", pc_stall, 1);
         chk("mw_no_flush", ifid_flush, 0);
      end
      step(1, OP_R, 11, 1, 2, 1, 0);
      chk("mw_then_flush", ifid_flush, 1);
      nop();
      chk("mw_stall_cnt", stall_cnt, 4);
      chk("mw_flush_cnt", flush_cnt, 2);

      // x0 is never a hazard, lui does not read rs1
      step(1, OP_I, 0, 0, 0, 0, 0);
      step(1, OP_R, 11, 0, 0, 0, 0);
      step(1, OP_LD, 1, 2, 0, 0, 0);
      chk("x0_fwd_a", fwd_a, 0);
      step(1, OP_LUI, 12, 0, 0, 0, 0);
      chk("lui_no_stall", pc_stall, 0);
      nop();

      // store/branch operand B forwarding, MEM preferred over WB
      step(1, OP_I, 20, 1, 0, 0, 0);
      step(1, OP_ST, 0, 2, 20, 0, 0);
      step(1, OP_BR, 0, 20, 20, 0, 0);
      chk("st_fwd_b_mem", fwd_b, 1);
      step(1, OP_I, 21, 0, 0, 0, 0);
      chk("br_fwd_wb", {fwd_a, fwd_b}, 4'b1010);
      step(1, OP_I, 21, 0, 0, 0, 0);
      step(1, OP_R, 22, 21, 21, 0, 0);
      step(1, OP_JAL, 1, 0, 0, 0, 0);
      chk("mem_over_wb", {fwd_a, fwd_b}, 4'b0101);
      nop();

      // reset pulsed during a load-use stall
      step(1, OP_LD, 13, 2, 0, 0, 0);
      step(1, OP_R, 14, 13, 0, 0, 0);
      chk("pre_rst_stall", pc_stall, 1);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_stall", pc_stall, 0);
      chk("rst_async_bubble", idex_bubble, 0);
      chk("rst_async_scnt", stall_cnt, 0);
      chk("rst_async_fcnt", flush_cnt, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      step(1, OP_R, 15, 3, 4, 0, 0);
      step(1, OP_R, 16, 6, 7, 0, 0);
      chk("post_rst_no_stall", pc_stall, 0);
      nop();
      chk("post_rst_scnt", stall_cnt, 0);

      // counter saturation
      for (int i = 0; i < 20; i++) step(1, OP_R, 17, 1, 2, 0, 1);
      nop();
      chk("stall_sat", stall_cnt, CMAX);
      for (int i = 0; i < 20; i++) step(1, OP_R, 17, 1, 2, 1, 0);
      nop();
      chk("flush_sat", flush_cnt, CMAX);
      nop();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
